turfio_turf_bus_master: RTL and testbench

TURFIO_TURF_BUS_MASTER -- requirements
Module: turfio_turf_bus_master

---
 rtl/turf_bus_defs.sv | 25 ++
 rtl/turfio_turf_bus_master.sv | 158 +++++++++++++++
 tb/tb_turfio_turf_bus_master.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turf_bus_defs.sv
// Shared TURF bus definitions: state encoding, word geometry and timing defaults.
// The slave-side register interface imports this same package.
package turf_bus_defs;

    localparam int BYTES_PER_WORD  = 4;
    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 32;
    localparam int TURN_CYCLES_DEF = 1;
    localparam int GAP_CYCLES_DEF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_TURN  = 3'd3,
        ST_RDATA = 3'd4,
        ST_GAP   = 3'd5
    } bus_state_t;

    // Terminal value of a 2-bit counter that runs for 'cycles' cycles.
    function automatic logic [1:0] last_count(input int cycles);
        return 2'(cycles - 1);
    endfunction

endpackage

// File: rtl/turfio_turf_bus_master.sv
// TURF byte-wide bus master: one address byte, then four LSB-first data bytes
// driven (write) or received after a bus turnaround (read). All outputs registered.
module turfio_turf_bus_master
    import turf_bus_defs::*;
#(
    parameter int TURN_CYCLES = TURN_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdat_i,
    output logic              busy_o,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdat_o,
    output logic              ncs_o,
    output logic              wnr_o,
    output logic [7:0]        dio_o,
    output logic              dio_oe_o,
    input  logic [7:0]        dio_i
);

    localparam logic [1:0] LAST_BYTE = last_count(BYTES_PER_WORD);
    localparam logic [1:0] LAST_TURN = last_count(TURN_CYCLES);
    localparam logic [1:0] LAST_GAP  = last_count(GAP_CYCLES);

    bus_state_t        r_state;
    logic              r_wr;
    logic [DATA_W-1:0] r_shift;
    logic [1:0]        r_byte_cnt;
    logic [1:0]        r_tg_cnt;
    logic              r_busy;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdat;
    logic              r_ncs;
    logic              r_wnr;
    logic [7:0]        r_dio;
    logic              r_oe;

    // Incoming byte lands at the top so four shifts leave byte 0 in [7:0].
    logic [DATA_W-1:0] w_rx_word;
    assign w_rx_word = {dio_i, r_shift[DATA_W-1:8]};

    // Transaction sequencer with registered bus and handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wr       <= 1'b0;
            r_shift    <= 32'd0;
            r_byte_cnt <= 2'd0;
            r_tg_cnt   <= 2'd0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_rdat     <= 32'd0;
            r_ncs      <= 1'b1;
            r_wnr      <= 1'b1;
            r_dio      <= 8'd0;
            r_oe       <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_state <= ST_ADDR;
                        r_wr    <= wr_i;
                        r_shift <= wdat_i;
                        r_busy  <= 1'b1;
                        r_ncs   <= 1'b0;
                        r_wnr   <= 1'b1;
                        r_oe    <= 1'b1;
                        r_dio   <= addr_i;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    r_byte_cnt <= 2'd0;
                    r_tg_cnt   <= 2'd0;
                    if (r_wr) begin
                        r_state <= ST_WDATA;
                        r_dio   <= r_shift[7:0];
                        r_shift <= {8'd0, r_shift[DATA_W-1:8]};
                    end else begin
                        // Release the bus before the slave may start driving.
                        r_state <= ST_TURN;
                        r_wnr   <= 1'b0;
                        r_oe    <= 1'b0;
                        r_dio   <= 8'd0;
                    end
                end
                ST_WDATA: begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        r_state  <= ST_GAP;
                        r_ack    <= 1'b1;
                        r_ncs    <= 1'b1;
                        r_oe     <= 1'b0;
                        r_dio    <= 8'd0;
                        r_tg_cnt <= 2'd0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_dio      <= r_shift[7:0];
                        r_shift    <= {8'd0, r_shift[DATA_W-1:8]};
                    end
                end
                ST_TURN: begin
                    if (r_tg_cnt == LAST_TURN) begin
                        r_state    <= ST_RDATA;
                        r_byte_cnt <= 2'd0;
                        r_tg_cnt   <= 2'd0;
                    end else begin
                        r_tg_cnt <= r_tg_cnt + 2'd1;
                    end
                end
                ST_RDATA: begin
                    r_shift <= w_rx_word;
                    if (r_byte_cnt == LAST_BYTE) begin
                        r_state  <= ST_GAP;
                        r_ack    <= 1'b1;
                        r_rdat   <= w_rx_word;
                        r_ncs    <= 1'b1;
                        r_wnr    <= 1'b1;
                        r_tg_cnt <= 2'd0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                ST_GAP: begin
                    if (r_tg_cnt == LAST_GAP) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_tg_cnt <= 2'd0;
                    end else begin
                        r_tg_cnt <= r_tg_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ncs   <= 1'b1;
                    r_wnr   <= 1'b1;
                    r_oe    <= 1'b0;
                    r_dio   <= 8'd0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign ack_o    = r_ack;
    assign rdat_o   = r_rdat;
    assign ncs_o    = r_ncs;
    assign wnr_o    = r_wnr;
    assign dio_o    = r_dio;
    assign dio_oe_o = r_oe;

endmodule

// File: tb/tb_turfio_turf_bus_master.sv
// Scoreboard bench for the TURF bus master: randomized transactions against a
// cycle-window reference model and a bus-level slave model; plus a TURN=3/GAP=3 instance.
module tb_turfio_turf_bus_master;

    localparam int TA = 1;
    localparam int GA = 1;
    localparam int TB = 3;
    localparam int GB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, req_a = 1'b0, wr_a = 1'b0;
    logic [7:0]  addr_a = 8'd0, din_a = 8'd0;
    logic [31:0] wdat_a = 32'd0;
    logic        busy_a, ack_a, ncs_a, wnr_a, oe_a;
    logic [7:0]  dio_a;
    logic [31:0] rdat_a;

    logic        rst_b = 1'b1, req_b = 1'b0;
    logic [7:0]  din_b = 8'd0;
    logic        busy_b, ack_b, ncs_b, wnr_b, oe_b;
    logic [7:0]  dio_b;
    logic [31:0] rdat_b;

    turfio_turf_bus_master #(.TURN_CYCLES(TA), .GAP_CYCLES(GA)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .wr_i(wr_a), .addr_i(addr_a),
        .wdat_i(wdat_a), .busy_o(busy_a), .ack_o(ack_a), .rdat_o(rdat_a),
        .ncs_o(ncs_a), .wnr_o(wnr_a), .dio_o(dio_a), .dio_oe_o(oe_a), .dio_i(din_a));

    turfio_turf_bus_master #(.TURN_CYCLES(TB), .GAP_CYCLES(GB)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .wr_i(1'b0), .addr_i(8'h5A),
        .wdat_i(32'h0), .busy_o(busy_b), .ack_o(ack_b), .rdat_o(rdat_b),
        .ncs_o(ncs_b), .wnr_o(wnr_b), .dio_o(dio_b), .dio_oe_o(oe_b), .dio_i(din_b));

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] exp_rdat;
        int          ack_edge;
    } txn_t;
    txn_t sbq[$];

    logic [31:0] ref_mem [256];
    logic [31:0] slave_mem [256];
    logic [31:0] last_rd = 32'd0;
    logic [31:0] shown_rdat = 32'd0;
    int          next_free = 0;
    int          cur_a = -1000;
    logic        cur_rd = 1'b0;
    logic [7:0]  cur_addr = 8'd0;
    logic [31:0] cur_wdat = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    // Request for one cycle; the model decides whether an idle master accepts it.
    task automatic pulse_req(input logic w, input logic [7:0] a, input logic [31:0] d);
        txn_t t;
        int   acc;
        @(posedge clk); #1;
        req_a = 1'b1; wr_a = w; addr_a = a; wdat_a = d;
        acc = edge_n + 1;
        if (acc >= next_free) begin
            t.wr = w; t.addr = a;
            t.ack_edge = acc + 5 + (w ? 0 : TA);
            if (w) begin
                ref_mem[a] = d;
                t.exp_rdat = last_rd;
            end else begin
                t.exp_rdat = ref_mem[a];
                last_rd = ref_mem[a];
            end
            sbq.push_back(t);
            cur_a = acc; cur_rd = !w; cur_addr = a; cur_wdat = d;
            next_free = acc + 6 + (w ? 0 : TA) + GA;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_a = 1'b0; wr_a = 1'($urandom); addr_a = 8'($urandom); wdat_a = $urandom;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sbq.size() != 0 || edge_n < next_free) && n < 200) begin
            idle_cycles(1);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_done timeout: pending %0d expected 0", sbq.size());
        end
    endtask

    // Bus-level slave for instance A: stores write words, returns read words LSB first.
    initial begin
        int sc; logic sw; logic [7:0] sa; logic [31:0] sbuf;
        sc = 0; sw = 1'b0; sa = 8'd0; sbuf = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                sc = 0; din_a = 8'($urandom);
            end else if (!ncs_a) begin
                if (sc == 0) sa = dio_a;
                if (sc == 1) sw = wnr_a;
                if (sw && sc >= 1 && sc <= 4) sbuf[8*(sc-1) +: 8] = dio_a;
                if (!sw && sc >= 1 + TA && sc <= 4 + TA) din_a = slave_mem[sa][8*(sc-1-TA) +: 8];
                else din_a = 8'($urandom);
                sc++;
            end else begin
                if (sc == 5 && sw) slave_mem[sa] = sbuf;
                sc = 0; din_a = 8'($urandom);
            end
        end
    end

    // Monitor for instance A: bus-window model each cycle, scoreboard pop on ack.
    initial begin
        int rel, data_end; logic exp_oe; txn_t t;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                rel = edge_n - cur_a;
                data_end = 4 + (cur_rd ? TA : 0);
                exp_oe = cur_rd ? (rel == 0) : (rel >= 0 && rel <= 4);
                check("ncs_o", ncs_a, (rel >= 0 && rel <= data_end) ? 1'b0 : 1'b1);
                check("busy_o", busy_a, (rel >= 0 && edge_n <= next_free - 2) ? 1'b1 : 1'b0);
                check("dio_oe_o", oe_a, exp_oe);
                check("wnr_o", wnr_a, (cur_rd && rel >= 1 && rel <= data_end) ? 1'b0 : 1'b1);
                check("oe_vs_wnr", oe_a & ~wnr_a, 1'b0);
                if (exp_oe) begin
                    if (rel == 0) check("dio_addr", dio_a, cur_addr);
                    else          check("dio_wbyte", dio_a, cur_wdat[8*(rel-1) +: 8]);
                end
                if (ack_a) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack at edge %0d: got 1 expected 0", edge_n);
                    end else begin
                        t = sbq.pop_front();
                        check("ack_latency", edge_n, t.ack_edge);
                        check("rdat_o", rdat_a, t.exp_rdat);
                        shown_rdat = t.exp_rdat;
                    end
                end else begin
                    check("rdat_hold", rdat_a, shown_rdat);
                end
            end
        end
    end

    // Instance B slave: always answers with a fixed word after TB turnaround cycles.
    initial begin
        int sc;
        logic [31:0] word_b;
        sc = 0; word_b = 32'hCAFEF00D;
        forever begin
            @(negedge clk);
            if (!ncs_b) begin
                if (sc >= 1 + TB && sc <= 4 + TB) din_b = word_b[8*(sc-1-TB) +: 8];
                else din_b = 8'($urandom);
                sc++;
            end else begin
                sc = 0; din_b = 8'($urandom);
            end
        end
    end

    initial begin
        int a, first_ack, prev_ack, hi_run, min_hi, acks;
        logic seen_low;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            slave_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ncs", ncs_a, 1'b1);
        check("rst_wnr", wnr_a, 1'b1);
        check("rst_oe", oe_a, 1'b0);
        check("rst_dio", dio_a, 8'd0);
        check("rst_ack", ack_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_rdat", rdat_a, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        next_free = edge_n + 1;

        pulse_req(1'b1, 8'h12, 32'hA1B2C3D4);
        wait_done();
        check("slave_write", slave_mem[8'h12], 32'hA1B2C3D4);
        ref_mem[8'h03] = 32'h12345678; slave_mem[8'h03] = 32'h12345678;
        pulse_req(1'b0, 8'h03, $urandom);
        wait_done();
        check("read_word", rdat_a, 32'h12345678);

        for (int i = 0; i < 20; i++) pulse_req(1'($urandom), 8'($urandom_range(0, 15)), $urandom);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            pulse_req(1'($urandom), 8'($urandom_range(0, 15)), $urandom);
            idle_cycles($urandom_range(0, 4));
        end
        wait_done();

        // Abort a read during its third data byte.
        pulse_req(1'b0, 8'h07, $urandom);
        a = cur_a;
        idle_cycles(1);
        while (edge_n < a + 4) idle_cycles(1);
        rst_a = 1'b1;
        sbq.delete();
        cur_a = -1000; next_free = 0; last_rd = 32'd0; shown_rdat = 32'd0;
        #1;
        check("abort_ncs", ncs_a, 1'b1);
        check("abort_oe", oe_a, 1'b0);
        check("abort_rdat", rdat_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", ack_a, 1'b0);
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        next_free = edge_n + 1;
        pulse_req(1'b0, 8'h07, $urandom);
        wait_done();
        check("post_abort_read", rdat_a, ref_mem[8'h07]);

        // TURN=3, GAP=3 instance with req held high for back-to-back reads.
        @(posedge clk); #1;
        req_b = 1'b1;
        a = edge_n + 1;
        first_ack = -1; prev_ack = -1; acks = 0;
        hi_run = 0; min_hi = 1000; seen_low = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            check("b_oe_vs_wnr", oe_b & ~wnr_b, 1'b0);
            if (ncs_b) hi_run++;
            else begin
                if (seen_low && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
                seen_low = 1'b1; hi_run = 0;
            end
            if (ack_b) begin
                acks++;
                check("b_rdat", rdat_b, 32'hCAFEF00D);
                if (first_ack < 0) first_ack = edge_n;
                else check("b_ack_spacing", edge_n - prev_ack, 6 + TB + GB);
                prev_ack = edge_n;
            end
        end
        req_b = 1'b0;
        check("b_ack_latency", first_ack, a + 5 + TB);
        check("b_ack_count", acks, 3);
        checks++;
        if (min_hi < GB + 1) begin
            errors++;
            $display("FAIL b_ncs_gap: got %0d expected at least %0d", min_hi, GB + 1);
        end

        check("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
